// File: rtl/sc_serial_mul_n.sv
// sc_serial_mul_n: stochastic-computing serial multiplier for NUM_INPUTS unsigned
// DATA_WIDTH-bit operands. Each operand is compared against a per-lane number source
// (counter digit or LFSR) to form a unipolar bitstream. The streams are ANDed, and the
// ones are counted over the stream length.

// One operand lane: latched operand, its LFSR, and its comparator.
module sc_serial_mul_n_lane #(
    parameter int DATA_WIDTH = 4,
    parameter int MODE       = 0,
    parameter int LANE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] op_i,
    input  logic [DATA_WIDTH-1:0] digit_i,
    output logic                  bit_o
);
    // Maximal-length tap masks for a left-shifting Fibonacci LFSR, widths 3..8
    function automatic logic [7:0] tap_mask(input int n);
        case (n)
            3:       tap_mask = 8'b0000_0110;
            4:       tap_mask = 8'b0000_1100;
            5:       tap_mask = 8'b0001_0100;
            6:       tap_mask = 8'b0011_0000;
            7:       tap_mask = 8'b0110_0000;
            default: tap_mask = 8'b1011_1000;
        endcase
    endfunction

    localparam logic [7:0]            TAP_ALL  = tap_mask(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] TAPS     = TAP_ALL[DATA_WIDTH-1:0];
    localparam int                    SEED_RAW = ((LANE + 1) * 5) % (1 << DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] SEED     = (SEED_RAW == 0) ? DATA_WIDTH'(1)
                                                                 : DATA_WIDTH'(SEED_RAW);

    logic [DATA_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[DATA_WIDTH-2:0], ^(lfsr_q & TAPS)};

    // Operand latches on accept; LFSR advances every RUN cycle and persists across runs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            lfsr_q <= SEED;
        end else begin
            if (load_i) op_q   <= op_i;
            if (step_i) lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = (MODE != 0) ? (lfsr_q < op_q) : (digit_i < op_q);
endmodule

// Top: control FSM, shared cycle counter, ones accumulator and result register.
module sc_serial_mul_n #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_INPUTS = 2,
    parameter int MODE       = 0,
    parameter int STREAM_LOG = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [DATA_WIDTH-1:0]            bin_data_in [NUM_INPUTS-1:0],
    output logic [DATA_WIDTH*NUM_INPUTS-1:0] bin_data_out,
    output logic                             busy,
    output logic                             done
);
    localparam int     PW     = DATA_WIDTH * NUM_INPUTS;
    localparam int     CW     = (MODE == 0) ? PW : STREAM_LOG;
    localparam int     AW     = (MODE == 0) ? PW : STREAM_LOG + 1;
    localparam int     SHIFT  = (MODE == 0) ? 0 : PW - STREAM_LOG;
    // Exact mode can never reach all-ones (prod < 2^PW - 1), so one saturating rule fits both
    localparam longint SAT_L  = (MODE == 0) ? ((longint'(1) << PW) - 1)
                                            : ((longint'(1) << STREAM_LOG) - 1);
    localparam logic [AW-1:0] ACC_SAT  = AW'(SAT_L);
    localparam logic [CW-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [AW-1:0]         acc_q, acc_d;
    logic [PW-1:0]         cnt_ext;
    logic [PW-1:0]         result;
    logic [NUM_INPUTS-1:0] stream;
    logic                  accept, running;

    assign accept  = (state_q == IDLE) && en;
    assign running = (state_q == RUN);
    assign cnt_ext = PW'(cnt_q);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        sc_serial_mul_n_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .MODE      (MODE),
            .LANE      (i)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_i (accept),
            .step_i (running),
            .op_i   (bin_data_in[i]),
            .digit_i(cnt_ext[i*DATA_WIDTH +: DATA_WIDTH]),
            .bit_o  (stream[i])
        );
    end

    // Count this cycle's AND bit, holding at the saturation value
    always_comb begin
        acc_d = acc_q;
        if ((&stream) && (acc_q != ACC_SAT)) acc_d = acc_q + 1'b1;
        result = PW'(acc_d) << SHIFT;
    end

    // IDLE -> RUN (L cycles) -> DONE (one cycle) -> IDLE; outputs registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            bin_data_out <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= acc_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q      <= DONE;
                        bin_data_out <= result;
                        done         <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sc_serial_mul_n.sv
// Bench for sc_serial_mul_n: three instances (N=4/K=2 exact, N=3/K=3 exact,
// N=4/K=2 LFSR with 64-bit streams) driven from one directed vector table plus
// hand sequences for back-to-back start, mid-run input change and mid-run reset.
module tb_sc_serial_mul_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] in_a [1:0];
    logic [2:0] in_b [2:0];
    logic [3:0] in_c [1:0];
    logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic [7:0] out_a, out_c;
    logic [8:0] out_b;
    logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;

    sc_serial_mul_n #(.DATA_WIDTH(4), .NUM_INPUTS(2), .MODE(0), .STREAM_LOG(8)) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .bin_data_in(in_a),
        .bin_data_out(out_a), .busy(busy_a), .done(done_a));
    sc_serial_mul_n #(.DATA_WIDTH(3), .NUM_INPUTS(3), .MODE(0), .STREAM_LOG(8)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .bin_data_in(in_b),
        .bin_data_out(out_b), .busy(busy_b), .done(done_b));
    sc_serial_mul_n #(.DATA_WIDTH(4), .NUM_INPUTS(2), .MODE(1), .STREAM_LOG(6)) u_dut_c (
        .clk(clk), .rst(rst), .en(en_c), .bin_data_in(in_c),
        .bin_data_out(out_c), .busy(busy_c), .done(done_c));

    int n_vec = 0;
    int n_err = 0;
    int sel   = 0;
    logic       done_s, busy_s;
    logic [8:0] out_s;

    always_comb begin
        done_s = done_a; busy_s = busy_a; out_s = 9'(out_a);
        case (sel)
            1:       begin done_s = done_b; busy_s = busy_b; out_s = out_b;        end
            2:       begin done_s = done_c; busy_s = busy_c; out_s = 9'(out_c);    end
            default: begin done_s = done_a; busy_s = busy_a; out_s = 9'(out_a);    end
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(input int s, input int o0, input int o1, input int o2, input logic e);
        case (s)
            0:       begin in_a[0] = 4'(o0); in_a[1] = 4'(o1); en_a = e; end
            1:       begin in_b[0] = 3'(o0); in_b[1] = 3'(o1); in_b[2] = 3'(o2); en_b = e; end
            default: begin in_c[0] = 4'(o0); in_c[1] = 4'(o1); en_c = e; end
        endcase
    endtask

    // Independent model of the LFSR instance: x^4+x^3+1 sources seeded 5 and 10
    logic [3:0] ms0, ms1;
    function automatic logic [3:0] lstep(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction
    task automatic model_reseed();
        ms0 = 4'd5;
        ms1 = 4'd10;
    endtask
    task automatic model_c(input int o0, input int o1, output int r);
        int acc = 0;
        for (int t = 0; t < 64; t++) begin
            if (int'(ms0) < o0 && int'(ms1) < o1 && acc < 63) acc++;
            ms0 = lstep(ms0);
            ms1 = lstep(ms1);
        end
        r = (acc << 2) & 255;
    endtask

    // Request a start, find the accept edge, then count edges until done
    task automatic run_op(input int s, input int o0, input int o1, input int o2, input int L,
                          output int wt, output int res, output int lat, output int bcnt);
        sel = s;
        wt  = 0;
        set_in(s, o0, o1, o2, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (busy_s) begin wt = k; break; end
        end
        set_in(s, o0, o1, o2, 1'b0);
        lat  = 0;
        bcnt = busy_s ? 1 : 0;
        for (int k = 1; k <= L + 8; k++) begin
            @(posedge clk); #1;
            if (busy_s) bcnt++;
            if (done_s) begin lat = k; break; end
        end
        res = int'(out_s);
    endtask

    typedef struct {
        int sel; int o0; int o1; int o2; int L; int exp;
    } vec_t;
    vec_t tbl [14];

    initial begin
        int wt, res, lat, bcnt, exp_r, cnt;
        tbl[0]  = '{0, 3, 5, 0, 256, 15};
        tbl[1]  = '{0, 15, 15, 0, 256, 225};
        tbl[2]  = '{0, 0, 9, 0, 256, 0};
        tbl[3]  = '{0, 7, 9, 0, 256, 63};
        tbl[4]  = '{0, 15, 1, 0, 256, 15};
        tbl[5]  = '{0, 1, 1, 0, 256, 1};
        tbl[6]  = '{0, 15, 0, 0, 256, 0};
        tbl[7]  = '{1, 7, 7, 7, 512, 343};
        tbl[8]  = '{1, 2, 3, 4, 512, 24};
        tbl[9]  = '{1, 0, 5, 5, 512, 0};
        tbl[10] = '{2, 0, 15, 0, 64, 0};
        tbl[11] = '{2, 15, 15, 0, 64, -1};
        tbl[12] = '{2, 8, 8, 0, 64, -1};
        tbl[13] = '{2, 15, 15, 0, 64, -1};

        set_in(0, 0, 0, 0, 1'b0);
        set_in(1, 0, 0, 0, 1'b0);
        set_in(2, 0, 0, 0, 1'b0);
        model_reseed();

        // Reset held for three edges, then released: everything idle and zero
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_busy", {busy_a, busy_b, busy_c}, 0);
        chk("rst_done", {done_a, done_b, done_c}, 0);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy_a | busy_b | busy_c | done_a | done_b | done_c) cnt++;
        end
        chk("idle_no_activity", cnt, 0);

        // Directed table; consecutive runs on one instance are back-to-back
        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].sel, tbl[i].o0, tbl[i].o1, tbl[i].o2, tbl[i].L, wt, res, lat, bcnt);
            exp_r = tbl[i].exp;
            if (tbl[i].sel == 2) begin
                model_c(tbl[i].o0, tbl[i].o1, exp_r);
                if (tbl[i].exp >= 0) chk($sformatf("v%0d_model_zero", i), exp_r, tbl[i].exp);
                if (tbl[i].o0 == 15 && tbl[i].o1 == 15)
                    chk($sformatf("v%0d_within32_of_225", i), (res >= 193 && res <= 257), 1);
            end
            chk($sformatf("v%0d_accept_wait", i), wt,
                (i > 0 && tbl[i-1].sel == tbl[i].sel) ? 2 : 1);
            chk($sformatf("v%0d_result", i), res, exp_r);
            chk($sformatf("v%0d_done_latency", i), lat, tbl[i].L);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, tbl[i].L + 1);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        // en held high and operands changed mid-run: latched operands rule, one done
        sel = 0;
        set_in(0, 3, 5, 0, 1'b1);
        @(posedge clk); #1;
        chk("hold_accept", busy_a, 1);
        lat = 0;
        for (int k = 1; k <= 270; k++) begin
            @(posedge clk); #1;
            if (k == 50) begin in_a[0] = 4'd15; in_a[1] = 4'd15; end
            if (done_a) begin lat = k; en_a = 1'b0; break; end
        end
        chk("hold_latency", lat, 256);
        chk("hold_result", out_a, 15);
        @(posedge clk); #1;
        chk("hold_single_done", {done_a, busy_a}, 0);
        @(posedge clk); #1;
        chk("hold_no_restart", busy_a, 0);

        // Reset at cnt=100 aborts the run: outputs cleared, no done afterwards
        set_in(0, 3, 5, 0, 1'b1);
        @(posedge clk); #1;
        en_a = 1'b0;
        chk("abort_accept", busy_a, 1);
        repeat (100) @(posedge clk);
        #3 rst = 1'b0;
        model_reseed();
        #1;
        chk("abort_out", out_a, 0);
        chk("abort_busy_done", {busy_a, done_a}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        cnt = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done_a | busy_a) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        chk("abort_out_held", out_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
